// File: rtl/leddc_core.sv
// LED display driver core: serial grayscale load into a ping-pong frame buffer
// and per-scanline PWM generation on 16 channel outputs, framed by Vsync.
`timescale 1ns/1ps
module leddc_core #(
  parameter int unsigned CH    = 16,
  parameter int unsigned LINES = 32,
  parameter int unsigned WBITS = 16
) (
  input  logic          GCK,
  input  logic          rst,
  input  logic          DCK,
  input  logic          DAI,
  input  logic          DEN,
  input  logic          Vsync,
  input  logic          mode,
  output logic [CH-1:0] OUT
);

  localparam int unsigned CW    = $clog2(CH);
  localparam int unsigned LW    = $clog2(LINES);
  localparam int unsigned PW    = CW + LW;
  localparam int unsigned BW    = $clog2(WBITS);
  localparam int unsigned DEPTH = 2 ** (PW + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WBITS - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(CH * LINES - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

  logic [2:0]       dck_sync;
  logic [1:0]       den_sync;
  logic [2:0]       dai_sync;
  logic [WBITS-2:0] word_sr;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    wr_ptr;
  logic             load_bank;
  logic             disp_bank;
  logic             disp_valid;
  logic             pending;
  logic             round;
  logic [LW-1:0]    line_idx;
  logic             vsync_d;
  logic [WBITS-1:0] cnt;

  logic [WBITS-1:0] mem [DEPTH];

  logic             dck_rise;
  logic [WBITS-1:0] shift_in;
  logic             word_done;
  logic             frame_done;
  logic             vs_fall;
  logic             wrap;
  logic             take;
  logic [WBITS-1:0] rd_word;
  logic [WBITS-1:0] rd_g;

  // DAI has one extra stage so the bit lines up with the last low DCK sample
  assign dck_rise   = dck_sync[1] & ~dck_sync[2];
  assign shift_in   = {dai_sync[2], word_sr};
  assign word_done  = den_sync[1] & dck_rise & (bit_cnt == BIT_LAST);
  assign frame_done = word_done & (wr_ptr == PTR_LAST);
  assign vs_fall    = vsync_d & ~Vsync;
  assign wrap       = vs_fall & (line_idx == LINE_LAST);
  // A new frame replaces a shown one only at the end of its second pass
  assign take       = wrap & (pending | frame_done) & (round | ~disp_valid);

  always_ff @(posedge GCK) begin
    if (!rst) begin
      dck_sync   <= '0;
      den_sync   <= '0;
      dai_sync   <= '0;
      word_sr    <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      load_bank  <= 1'b0;
      disp_bank  <= 1'b0;
      disp_valid <= 1'b0;
      pending    <= 1'b0;
      round      <= 1'b0;
      line_idx   <= '0;
      vsync_d    <= 1'b0;
      cnt        <= '0;
    end else begin
      dck_sync <= {dck_sync[1:0], DCK};
      den_sync <= {den_sync[0], DEN};
      dai_sync <= {dai_sync[1:0], DAI};
      vsync_d  <= Vsync;

      if (!den_sync[1]) begin
        bit_cnt <= '0;
      end else if (dck_rise) begin
        word_sr <= shift_in[WBITS-1:1];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end

      if (word_done)  wr_ptr    <= wr_ptr + 1'b1;
      if (frame_done) load_bank <= ~load_bank;

      if (take) begin
        disp_bank  <= frame_done ? load_bank : ~load_bank;
        disp_valid <= 1'b1;
        pending    <= 1'b0;
        round      <= 1'b0;
      end else begin
        if (frame_done) pending <= 1'b1;
        if (wrap)       round   <= ~round;
      end

      if (vs_fall) line_idx <= wrap ? '0 : line_idx + 1'b1;

      if (!Vsync)          cnt <= '0;
      else if (cnt != '1)  cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge GCK) begin
    if (rst && word_done) mem[{load_bank, wr_ptr}] <= shift_in;
  end

  always_comb begin
    OUT     = '0;
    rd_word = '0;
    rd_g    = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      rd_word = mem[{disp_bank, line_idx, CW'(c)}];
      rd_g    = mode ? (rd_word >> 1) : rd_word;
      OUT[c]  = Vsync & disp_valid & (cnt < rd_g);
    end
  end

endmodule

// File: tb/tb_leddc_core.sv
// Bench for leddc_core: frame-level display model compared every cycle,
// plus literal per-channel high counts on selected scanlines.
`timescale 1ns/1ps
module tb_leddc_core;
  localparam int unsigned CH = 16;
  localparam int unsigned TL = 4;
  localparam int unsigned NW = CH * TL;

  logic GCK = 1'b0;
  logic rst = 1'b0;
  logic DCK = 1'b0;
  logic DAI = 1'b0;
  logic DEN = 1'b0;
  logic Vsync = 1'b0;
  logic mode = 1'b1;
  logic [CH-1:0] OUT;

  leddc_core #(.CH(CH), .LINES(TL), .WBITS(16)) dut (
    .GCK(GCK), .rst(rst), .DCK(DCK), .DAI(DAI), .DEN(DEN),
    .Vsync(Vsync), .mode(mode), .OUT(OUT)
  );

  always #5 GCK = ~GCK;

  logic [15:0] frames [3][NW];
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Display model: which frame is shown, current scanline, passes since last swap
  int m_line = 0;
  int m_passes = 0;
  int m_shown = 0;
  int m_pend_idx = 0;
  bit m_valid = 1'b0;
  bit m_pending = 1'b0;
  int hi_idx = 0;
  int hi_cnt [CH];
  logic [CH-1:0] exp_out;
  int g;

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge GCK);
    #1;
  endtask

  task automatic model_reset();
    m_line = 0; m_passes = 0; m_valid = 1'b0; m_pending = 1'b0;
  endtask

  task automatic model_fall();
    m_line = (m_line + 1) % TL;
    if (m_line == 0) begin
      m_passes++;
      if (m_pending && (!m_valid || (m_passes % 2 == 0))) begin
        m_valid = 1'b1; m_shown = m_pend_idx; m_pending = 1'b0; m_passes = 0;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    DAI = b; DCK = 1'b0; repeat (4) tick();
    DCK = 1'b1; repeat (4) tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic send_frame(input int idx);
    DEN = 1'b1;
    for (int k = 0; k < NW; k++) send_word(frames[idx][k]);
    DEN = 1'b0; DCK = 1'b0;
    m_pending = 1'b1; m_pend_idx = idx;
  endtask

  task automatic vs_line(input int nh, input int nl);
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    Vsync = 1'b1; repeat (nh) tick();
    Vsync = 1'b0; model_fall(); repeat (nl) tick();
  endtask

  task automatic take_frame(input string name);
    for (int i = 0; i < 2 * TL && !m_valid; i++) vs_line(8, 4);
    check(name, int'(m_valid), 1);
  endtask

  function automatic int hi_sum();
    int s = 0;
    for (int c = 0; c < CH; c++) s += hi_cnt[c];
    return s;
  endfunction

  always @(negedge GCK) begin
    if (chk_en) begin
      exp_out = '0;
      if (Vsync && m_valid) begin
        for (int c = 0; c < CH; c++) begin
          g = int'(frames[m_shown][m_line * CH + c]);
          if (mode) g = g / 2;
          exp_out[c] = (hi_idx < g);
        end
      end
      n_checks++;
      if (OUT !== exp_out) begin
        n_fail++;
        $display("FAIL out_cycle t=%0t line=%0d got=%h expected=%h", $time, m_line, OUT, exp_out);
      end
      if (Vsync) begin
        for (int c = 0; c < CH; c++) if (OUT[c]) hi_cnt[c]++;
        if (hi_idx < 65535) hi_idx++;
      end else begin
        hi_idx = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    for (int k = 0; k < NW; k++) begin
      frames[0][k] = 16'(k * 256);
      frames[1][k] = 16'(2 * k + 2);
      frames[2][k] = 16'(k * 16);
    end
    frames[0][15] = 16'hFFFF;
    frames[2][0]  = 16'h0001;
    frames[2][1]  = 16'hFFFF;
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;

    repeat (5) tick();
    model_reset();
    rst = 1'b1;
    chk_en = 1'b1;

    acc = 0;
    repeat (10) begin vs_line(5, 5); acc += hi_sum(); end
    check("idle_dark", acc, 0);

    send_frame(0);
    repeat (10) tick();
    take_frame("frame_a_taken");

    fork
      vs_line(32768, 4);
      begin repeat (20) tick(); send_frame(1); end
    join
    check("a_l0_ch0", hi_cnt[0], 0);
    check("a_l0_ch5", hi_cnt[5], 16'h0280);
    check("a_l0_ch8", hi_cnt[8], 1024);
    check("a_l0_ch15_max", hi_cnt[15], 32767);

    repeat (3) vs_line(16, 4);
    vs_line(16, 4);
    check("pass2_a_ch5", hi_cnt[5], 16);
    check("pass2_a_ch0", hi_cnt[0], 0);
    repeat (3) vs_line(16, 4);

    vs_line(16, 4);
    check("b_l0_ch0", hi_cnt[0], 1);
    check("b_l0_ch5", hi_cnt[5], 6);
    check("b_l0_ch15", hi_cnt[15], 16);
    repeat (3) vs_line(16, 4);

    DEN = 1'b1;
    repeat (5) send_word(16'hAAAA);
    DEN = 1'b0; DCK = 1'b0;
    tick();
    rst = 1'b0; model_reset();
    repeat (3) tick();
    rst = 1'b1;

    acc = 0;
    repeat (2) begin vs_line(8, 4); acc += hi_sum(); end
    check("post_reset_dark", acc, 0);

    DEN = 1'b1;
    repeat (9) send_bit(1'b1);
    DEN = 1'b0; DCK = 1'b0;
    repeat (4) tick();
    send_frame(2);
    mode = 1'b0;
    repeat (10) tick();
    take_frame("frame_c_taken");

    vs_line(20, 4);
    check("serial_lsb_ch0", hi_cnt[0], 1);
    check("m0_max_ch1", hi_cnt[1], 20);
    check("m0_ch2", hi_cnt[2], 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
